seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, multicycle-capable ALU for the multicycle datapath. Single-cycle ARM-style operations (ADD, SUB, AND, ORR, EOR, MOV) complete in one cycle. An iterative shift-add MUL and an optional restoring UDIV take WIDTH+1 cycles. Operands are accepted on a start/busy/done handshake, and Result/ALUFlags are registered and held, so the controller FSM can stall on long operations without re-presenting operands.

## Interface
- WIDTH, 32, datapath width in bits (≥ 4)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- SrcA  input  WIDTH  operand A, captured on accepted start
- SrcB  input  WIDTH  operand B, captured on accepted start
- ALUControl  input  3  opcode, captured on accepted start
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse; Result/ALUFlags valid from this cycle
- Result  output  WIDTH  registered result, held until the next done
- ALUFlags  output  4  registered {N, Z, C, V}, held with Result

## Operation
- Opcodes:
  - 000 ADD: A+B
  - 001 SUB: A+~B+1
  - 010 AND
  - 011 ORR
  - 100 EOR
  - 101 MOV: B
  - 110 MUL: low WIDTH bits of A×B, unsigned
  - 111 UDIV: A/B, unsigned, only when enabled (see Configuration)
- States: IDLE, CALC, DONE.
  - IDLE→DONE: start with opcode 000–101.
  - IDLE→CALC: start with opcode 110/111. Counter loads WIDTH; A, B and the accumulator are captured.
  - CALC: one iteration per cycle, counter decrements. CALC→DONE on the edge where counter=1.
  - DONE→IDLE unconditionally. done=1 only in DONE.
- Arithmetic:
  - Sum is computed WIDTH+1 bits wide.
  - C = sum[WIDTH]. For SUB, C=1 means no borrow.
  - V = ~(A[msb]^B[msb]^sub) & (A[msb]^sum[msb-1 index WIDTH-1]).
- C and V are forced to 0 for AND, ORR, EOR, MOV and MUL.
- N = Result[WIDTH-1] and Z = (Result==0) for every opcode.
- MUL: shift-add over WIDTH iterations. Product bits above WIDTH-1 are discarded; there is no overflow flag.
- UDIV, restoring: quotient goes to Result, remainder is discarded.
  - B=0: Result = all ones, V=1, C=0.
- start while busy=1 (CALC or DONE) is ignored. Operands are not re-sampled.
- Operand or opcode changes after acceptance have no effect.
- Reset asserted mid-operation aborts immediately to IDLE. Any pending done is lost.

## Timing
- Reset values: busy=0, done=0, Result=0, ALUFlags=4'b0000, state=IDLE, counter=0.
- Single-cycle ops: start sampled at edge k → done=1 and valid Result during cycle k+1 → IDLE at k+2. Back-to-back throughput is one op per 2 cycles.
- MUL/UDIV: start at edge k → CALC for cycles k+1..k+WIDTH → done during cycle k+WIDTH+1. Latency is WIDTH+1.
- busy rises in the cycle after the accepting edge and falls together with done.
- Result/ALUFlags change only on the edge that enters DONE and are stable at all other times.

## Configuration
- SEQ_ALU_UDIV_EN defined: opcode 111 performs UDIV as above, sharing the CALC counter and iteration register with MUL.
- Not defined: the divider logic is not built. Opcode 111 is treated as single-cycle:
  - Result=0, ALUFlags=4'b0100 (Z=1), done at k+1.

## Test plan
- Reset in any state → busy=0, done=0, Result=0, ALUFlags=0 immediately, before any clock edge.
- WIDTH=32, SUB A=5, B=5 → done at k+1, Result=0, flags N=0 Z=1 C=1 V=0. ADD A=0x7FFFFFFF, B=1 → Result 0x80000000, N=1 V=1 C=0.
- MUL A=0x0001_0000, B=0x0001_0001 → done exactly 33 cycles after the start edge, Result=0x0001_0000, C=V=0. During cycles 1..32 a second start with different operands is ignored.
- EOR A=0xFFFF0000, B=0x0F0F0F0F → Result 0xF0F00F0F, N=1, C=V=0. Result is still held 10 cycles later with start low.
- With SEQ_ALU_UDIV_EN: UDIV 100/7 → Result 14 after 33 cycles. UDIV x/0 → Result 0xFFFFFFFF, V=1. Without the macro: opcode 111 → Result 0, Z=1, done at k+1.
- MUL started, reset pulsed low in cycle 10 of CALC → no done. A fresh ADD 2+3 after release → Result 5 at k+1.

Source files
------------

// File: rtl/seq_alu.sv
// Multicycle ALU: single-cycle ADD/SUB/AND/ORR/EOR/MOV, iterative shift-add MUL,
// and a restoring UDIV built only when SEQ_ALU_UDIV_EN is defined.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [2:0]       ALUControl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ALUFlags
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_ORR = 3'b011;
    localparam logic [2:0] OP_EOR = 3'b100;
    localparam logic [2:0] OP_MOV = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
`ifdef SEQ_ALU_UDIV_EN
    localparam logic [2:0] OP_UDIV = 3'b111;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] result_r;
    logic [3:0]       flags_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_r;

    logic             accept_s;
    logic             multi_s;
    logic             sub_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] sc_res_s;
    logic             sc_c_s;
    logic             sc_v_s;
    logic [3:0]       sc_flags_s;

    logic [WIDTH-1:0] iter_a_s;
    logic [WIDTH-1:0] iter_b_s;
    logic [WIDTH-1:0] iter_acc_s;
    logic [WIDTH-1:0] fin_res_s;
    logic [3:0]       fin_flags_s;

`ifdef SEQ_ALU_UDIV_EN
    logic [2:0]       op_r;
    logic [WIDTH:0]   div_trial_s;
    logic [WIDTH:0]   div_diff_s;
    logic             div_ok_s;
    logic             div_unused_s;

    // A surviving remainder is always below the divisor, so the diff MSB carries no information.
    assign div_unused_s = div_diff_s[WIDTH];
`endif

    assign accept_s = (state_r == IDLE) && start;

    // Decide whether the presented opcode needs the iterative CALC phase
    always_comb begin
        multi_s = 1'b0;
`ifdef SEQ_ALU_UDIV_EN
        if ((ALUControl == OP_MUL) || (ALUControl == OP_UDIV)) begin
            multi_s = 1'b1;
        end else begin
            multi_s = 1'b0;
        end
`else
        if (ALUControl == OP_MUL) begin
            multi_s = 1'b1;
        end else begin
            multi_s = 1'b0;
        end
`endif
    end

    // Single-cycle result and flags straight from the presented operands
    always_comb begin
        sub_s    = (ALUControl == OP_SUB);
        sum_s    = {1'b0, SrcA} + {1'b0, SrcB ^ {WIDTH{sub_s}}} + {{WIDTH{1'b0}}, sub_s};
        sc_res_s = {WIDTH{1'b0}};
        sc_c_s   = 1'b0;
        sc_v_s   = 1'b0;
        case (ALUControl)
            OP_ADD, OP_SUB: begin
                sc_res_s = sum_s[WIDTH-1:0];
                sc_c_s   = sum_s[WIDTH];
                sc_v_s   = ~(SrcA[WIDTH-1] ^ SrcB[WIDTH-1] ^ sub_s) & (SrcA[WIDTH-1] ^ sum_s[WIDTH-1]);
            end
            OP_AND:  sc_res_s = SrcA & SrcB;
            OP_ORR:  sc_res_s = SrcA | SrcB;
            OP_EOR:  sc_res_s = SrcA ^ SrcB;
            OP_MOV:  sc_res_s = SrcB;
            // Opcode 111 without the divider lands here: zero result, Z set.
            default: sc_res_s = {WIDTH{1'b0}};
        endcase
        sc_flags_s = {sc_res_s[WIDTH-1], (sc_res_s == {WIDTH{1'b0}}), sc_c_s, sc_v_s};
    end

    // One shift-add (MUL) or restoring-divide (UDIV) step on the iteration registers
    always_comb begin
        iter_a_s    = {WIDTH{1'b0}};
        iter_b_s    = {WIDTH{1'b0}};
        iter_acc_s  = {WIDTH{1'b0}};
        fin_res_s   = {WIDTH{1'b0}};
        fin_flags_s = 4'b0000;
`ifdef SEQ_ALU_UDIV_EN
        div_trial_s = {acc_r, a_r[WIDTH-1]};
        div_diff_s  = div_trial_s - {1'b0, b_r};
        div_ok_s    = (div_trial_s >= {1'b0, b_r});
        if (op_r == OP_UDIV) begin
            // Quotient bits shift into a_r; b_r holds the divisor.
            iter_a_s    = {a_r[WIDTH-2:0], div_ok_s};
            iter_b_s    = b_r;
            iter_acc_s  = div_ok_s ? div_diff_s[WIDTH-1:0] : div_trial_s[WIDTH-1:0];
            fin_res_s   = iter_a_s;
            fin_flags_s = {iter_a_s[WIDTH-1], (iter_a_s == {WIDTH{1'b0}}), 1'b0,
                           (b_r == {WIDTH{1'b0}})};
        end else begin
            iter_a_s    = {a_r[WIDTH-2:0], 1'b0};
            iter_b_s    = {1'b0, b_r[WIDTH-1:1]};
            iter_acc_s  = b_r[0] ? (acc_r + a_r) : acc_r;
            fin_res_s   = iter_acc_s;
            fin_flags_s = {iter_acc_s[WIDTH-1], (iter_acc_s == {WIDTH{1'b0}}), 2'b00};
        end
`else
        iter_a_s    = {a_r[WIDTH-2:0], 1'b0};
        iter_b_s    = {1'b0, b_r[WIDTH-1:1]};
        iter_acc_s  = b_r[0] ? (acc_r + a_r) : acc_r;
        fin_res_s   = iter_acc_s;
        fin_flags_s = {iter_acc_s[WIDTH-1], (iter_acc_s == {WIDTH{1'b0}}), 2'b00};
`endif
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = multi_s ? CALC : DONE;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == CNT_ONE) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register plus busy/done registered from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
        end
    end

    // Operand capture, iteration registers and CALC counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {CW{1'b0}};
            a_r   <= {WIDTH{1'b0}};
            b_r   <= {WIDTH{1'b0}};
            acc_r <= {WIDTH{1'b0}};
`ifdef SEQ_ALU_UDIV_EN
            op_r  <= 3'b000;
`endif
        end else if (accept_s) begin
            cnt_r <= multi_s ? CNT_LOAD : {CW{1'b0}};
            a_r   <= SrcA;
            b_r   <= SrcB;
            acc_r <= {WIDTH{1'b0}};
`ifdef SEQ_ALU_UDIV_EN
            op_r  <= ALUControl;
`endif
        end else if (state_r == CALC) begin
            cnt_r <= cnt_r - CNT_ONE;
            a_r   <= iter_a_s;
            b_r   <= iter_b_s;
            acc_r <= iter_acc_s;
        end
    end

    // Result/flags load only on the edge that enters DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_r <= {WIDTH{1'b0}};
            flags_r  <= 4'b0000;
        end else if (accept_s && !multi_s) begin
            result_r <= sc_res_s;
            flags_r  <= sc_flags_s;
        end else if ((state_r == CALC) && (cnt_r == CNT_ONE)) begin
            result_r <= fin_res_s;
            flags_r  <= fin_flags_s;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign Result   = result_r;
    assign ALUFlags = flags_r;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: table-driven ops with a result scoreboard,
// plus hand sequences for start-while-busy, result hold and mid-operation reset.
module tb_seq_alu;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic [2:0]   ALUControl;
    logic         busy;
    logic         done;
    logic [W-1:0] Result;
    logic [3:0]   ALUFlags;

    seq_alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUControl (ALUControl),
        .busy       (busy),
        .done       (done),
        .Result     (Result),
        .ALUFlags   (ALUFlags)
    );

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   flags;
        int           lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   flags;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vt[14];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one op, push its expectation, wait (bounded) for done and check it.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] res, input logic [3:0] fl, input int lat,
                          input bit meddle);
        exp_t e;
        exp_t got;
        int   cyc;
        @(negedge clk);
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        start      = 1'b1;
        @(posedge clk);
        e.res   = res;
        e.flags = fl;
        sb.push_back(e);
        #1;
        start      = 1'b0;
        SrcA       = $urandom;
        SrcB       = $urandom;
        ALUControl = 3'($urandom_range(0, 7));
        cyc = 0;
        while (1'b1) begin
            @(negedge clk);
            cyc++;
            if (done || cyc > lat + 4) break;
            if (meddle && cyc <= lat - 2) begin
                start      = 1'b1;
                SrcA       = $urandom;
                SrcB       = $urandom;
                ALUControl = 3'b000;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("latency", 64'(cyc), 64'(lat));
        chk("busy_at_done", 64'(busy), 64'd1);
        got.res   = {W{1'b1}};
        got.flags = 4'b1111;
        if (sb.size() > 0) got = sb.pop_front();
        chk("result", 64'(Result), 64'(got.res));
        chk("flags", 64'(ALUFlags), 64'(got.flags));
        @(negedge clk);
        chk("busy_after", 64'(busy), 64'd0);
        chk("done_after", 64'(done), 64'd0);
        chk("result_held", 64'(Result), 64'(got.res));
    endtask

    initial begin
        int seen;
        reset      = 1'b0;
        start      = 1'b0;
        SrcA       = '0;
        SrcB       = '0;
        ALUControl = 3'b000;
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(Result), 64'd0);
        chk("rst_flags", 64'(ALUFlags), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        vt[0]  = '{3'b001, 32'd5,          32'd5,          32'd0,          4'b0110, 1};
        vt[1]  = '{3'b000, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  4'b1001, 1};
        vt[2]  = '{3'b110, 32'h0001_0000,  32'h0001_0001,  32'h0001_0000,  4'b0000, 33};
        vt[3]  = '{3'b100, 32'hFFFF_0000,  32'h0F0F_0F0F,  32'hF0F0_0F0F,  4'b1000, 1};
        vt[4]  = '{3'b010, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  4'b1000, 1};
        vt[5]  = '{3'b011, 32'h1234_0000,  32'h0000_5678,  32'h1234_5678,  4'b0000, 1};
        vt[6]  = '{3'b101, 32'hDEAD_BEEF,  32'd0,          32'd0,          4'b0100, 1};
        vt[7]  = '{3'b000, 32'hFFFF_FFFF,  32'd1,          32'd0,          4'b0110, 1};
        vt[8]  = '{3'b001, 32'd3,          32'd5,          32'hFFFF_FFFE,  4'b1000, 1};
        vt[9]  = '{3'b001, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  4'b0011, 1};
        vt[10] = '{3'b110, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          4'b0000, 33};
        vt[11] = '{3'b110, 32'h0001_0000,  32'h0001_0000,  32'd0,          4'b0100, 33};
`ifdef SEQ_ALU_UDIV_EN
        vt[12] = '{3'b111, 32'd100,        32'd7,          32'd14,         4'b0000, 33};
        vt[13] = '{3'b111, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  4'b1001, 33};
`else
        vt[12] = '{3'b111, 32'd100,        32'd7,          32'd0,          4'b0100, 1};
        vt[13] = '{3'b111, 32'h1234_5678,  32'd0,          32'd0,          4'b0100, 1};
`endif

        for (int i = 0; i < 14; i++) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].flags, vt[i].lat, (i == 2));
        end

        // Result must stay put with start low.
        run_op(3'b100, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 4'b1000, 1, 1'b0);
        repeat (10) @(negedge clk);
        chk("hold_result", 64'(Result), 64'hF0F0_0F0F);
        chk("hold_flags", 64'(ALUFlags), 64'h8);

        // Reset in the middle of a MUL: outputs clear at once, no done afterwards.
        @(negedge clk);
        ALUControl = 3'b110;
        SrcA       = 32'h0001_0000;
        SrcB       = 32'h0001_0001;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("calc_busy", 64'(busy), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_result", 64'(Result), 64'd0);
        chk("abort_flags", 64'(ALUFlags), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        seen  = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("no_done_after_abort", 64'(seen), 64'd0);
        run_op(3'b000, 32'd2, 32'd3, 32'd5, 4'b0000, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
